// File: rtl/slave_port_arbiter_if.sv
// Request/grant bundle between the per-slave arbiter and its four masters plus the slave.
// The arbiter side uses the slave modport; the requester/bench side uses master.
interface slave_port_arbiter_if;
  logic [3:0] iMstReq;
  logic       iSlvAck;
  logic [3:0] oGnt;
  logic       oGntVld;
  logic [1:0] oGntIdx;
  logic       oSlvReq;
  logic [3:0] oMstAck;
  logic       oTimeout;
  logic       oDbgState;
  logic [1:0] oDbgPtr;

  modport slave (
    input  iMstReq, iSlvAck,
    output oGnt, oGntVld, oGntIdx, oSlvReq, oMstAck, oTimeout, oDbgState, oDbgPtr
  );

  modport master (
    output iMstReq, iSlvAck,
    input  oGnt, oGntVld, oGntIdx, oSlvReq, oMstAck, oTimeout, oDbgState, oDbgPtr
  );
endinterface

// File: rtl/slave_port_arbiter.sv
// Round-robin arbiter and grant sequencer for one slave port of the 4x4 req/ack crossbar.
// Optional grant timeout is built only when SLV_ARB_TIMEOUT_EN is defined.
//
// Handshake: a master holds iMstReq[n] until it sees oMstAck[n]; the slave sees oSlvReq while
// the granted master keeps requesting and answers with a one-cycle iSlvAck. Dropping the request
// while granted aborts the transaction and frees the port on the next edge.
module slave_port_arbiter #(
  parameter int unsigned TO_W   = 8,
  parameter int unsigned TO_CYC = 200
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  slave_port_arbiter_if.slave  bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic [3:0] r_gnt;
  logic       r_gnt_vld;
  logic [1:0] r_gnt_idx;
  logic [1:0] r_ptr;
  logic       r_timeout;

  logic [3:0] w_gnt_nxt;
  logic       w_gnt_vld_nxt;
  logic [1:0] w_gnt_idx_nxt;
  logic [1:0] w_ptr_nxt;
  logic       w_timeout_nxt;

  logic       w_pick_vld;
  logic [1:0] w_pick_idx;
  logic       w_abort;
  logic       w_expire;
  logic       w_release;

  // Rotating priority search: the lowest offset from r_ptr wins, so scan offsets high to low.
  always_comb begin
    logic [1:0] v_cand;
    w_pick_vld = 1'b0;
    w_pick_idx = r_ptr;
    v_cand     = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      v_cand = r_ptr + 2'(i);
      if (bus.iMstReq[v_cand]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = v_cand;
      end
    end
  end

  assign w_abort   = (r_state == S_GRANT) && !bus.iSlvAck && !bus.iMstReq[r_gnt_idx];
  assign w_release = (r_state == S_GRANT) && (bus.iSlvAck || w_abort || w_expire);

`ifdef SLV_ARB_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_cnt_nxt;

  // An ack on the expiry cycle wins, so the release is reported as a normal ack.
  assign w_expire = (r_state == S_GRANT) && !bus.iSlvAck &&
                    (r_to_cnt == TO_W'(TO_CYC - 1));

  always_comb begin
    w_to_cnt_nxt = r_to_cnt;
    if (r_state == S_IDLE) begin
      w_to_cnt_nxt = '0;
    end else if (!w_release) begin
      w_to_cnt_nxt = r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= w_to_cnt_nxt;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TO_W > 0) && (TO_CYC > 0);
  assign w_expire     = 1'b0;
`endif

  // State register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_pick_vld) w_next_state = S_GRANT;
      S_GRANT: if (w_release)  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered grant outputs and pointer
  always_comb begin
    w_gnt_nxt     = r_gnt;
    w_gnt_vld_nxt = r_gnt_vld;
    w_gnt_idx_nxt = r_gnt_idx;
    w_ptr_nxt     = r_ptr;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_gnt_nxt     = 4'b0001 << w_pick_idx;
          w_gnt_vld_nxt = 1'b1;
          w_gnt_idx_nxt = w_pick_idx;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_gnt_nxt     = 4'b0000;
          w_gnt_vld_nxt = 1'b0;
          w_ptr_nxt     = r_gnt_idx + 2'd1;
          w_timeout_nxt = w_expire;
        end
      end
      default: begin
        w_gnt_nxt     = 4'b0000;
        w_gnt_vld_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_gnt     <= 4'b0000;
      r_gnt_vld <= 1'b0;
      r_gnt_idx <= 2'd0;
      r_ptr     <= 2'd0;
      r_timeout <= 1'b0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_gnt_vld <= w_gnt_vld_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.oGnt      = r_gnt;
  assign bus.oGntVld   = r_gnt_vld;
  assign bus.oGntIdx   = r_gnt_idx;
  assign bus.oTimeout  = r_timeout;
  assign bus.oSlvReq   = r_gnt_vld & bus.iMstReq[r_gnt_idx];
  assign bus.oMstAck   = r_gnt & {4{bus.iSlvAck}};
  assign bus.oDbgState = r_state;
  assign bus.oDbgPtr   = r_ptr;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Self-checking bench for slave_port_arbiter: directed scenarios plus random traffic against
// a cycle-level reference model of the round-robin rules.
module tb_slave_port_arbiter;
`ifdef SLV_ARB_TIMEOUT_EN
  localparam int TB_TO_CYC = 5;
  localparam bit TB_TO_EN  = 1'b1;
`else
  localparam int TB_TO_CYC = 200;
  localparam bit TB_TO_EN  = 1'b0;
`endif

  logic clk;
  logic rst_n;
  slave_port_arbiter_if bus ();

  slave_port_arbiter #(.TO_W(8), .TO_CYC(TB_TO_CYC)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: granted master (-1 = none), pointer, last index, timeout pulse, age
  int m_g;
  int m_ptr;
  int m_idx;
  int m_to;
  int m_age;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_g = -1; m_ptr = 0; m_idx = 0; m_to = 0; m_age = 0;
  endtask

  task automatic do_reset();
    bus.iMstReq = 4'b0000;
    bus.iSlvAck = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: check registered outputs, apply inputs, check combinational outputs, advance model.
  task automatic step(input logic [3:0] req, input logic ack);
    logic [3:0] exp_ack;
    check("gnt",     {28'd0, bus.oGnt},    (m_g >= 0) ? (32'd1 << m_g) : 32'd0);
    check("gnt_vld", {31'd0, bus.oGntVld}, (m_g >= 0) ? 32'd1 : 32'd0);
    check("gnt_idx", {30'd0, bus.oGntIdx}, m_idx);
    check("timeout", {31'd0, bus.oTimeout}, m_to);
    check("ptr",     {30'd0, bus.oDbgPtr}, m_ptr);
    bus.iMstReq = req;
    bus.iSlvAck = ack;
    #1;
    exp_ack = (m_g >= 0 && ack) ? (4'b0001 << m_g) : 4'b0000;
    check("mst_ack", {28'd0, bus.oMstAck}, {28'd0, exp_ack});
    check("slv_req", {31'd0, bus.oSlvReq}, (m_g >= 0 && req[m_g]) ? 32'd1 : 32'd0);
    m_to = 0;
    if (m_g < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_g < 0 && req[(m_ptr + k) % 4]) m_g = (m_ptr + k) % 4;
      end
      if (m_g >= 0) begin
        m_idx = m_g;
        m_age = 0;
      end
    end else begin
      if (ack || !req[m_g] || (TB_TO_EN && m_age == TB_TO_CYC - 1)) begin
        m_to  = (!ack && TB_TO_EN && m_age == TB_TO_CYC - 1) ? 1 : 0;
        m_ptr = (m_g + 1) % 4;
        m_g   = -1;
      end else begin
        m_age++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] r_req;
  int         hold;
  int         order_q[$];

  initial begin
    rst_n = 1'b0;
    do_reset();

    // Reset state
    check("rst_gnt",   {28'd0, bus.oGnt},      32'd0);
    check("rst_state", {31'd0, bus.oDbgState}, 32'd0);

    // Single request from m2, ack at cycle 3
    step(4'b0100, 1'b0);
    check("single_gnt", {28'd0, bus.oGnt}, 32'h4);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    check("single_ack", {28'd0, bus.oMstAck}, 32'h0);
    step(4'b0100, 1'b1);
    check("single_ptr", {30'd0, bus.oDbgPtr}, 32'd3);
    step(4'b0000, 1'b0);

    // Wrap: ptr=3, m0 and m3 request -> m3 first then m0
    step(4'b1001, 1'b0);
    check("wrap_first", {30'd0, bus.oGntIdx}, 32'd3);
    step(4'b1001, 1'b1);
    step(4'b0001, 1'b0);
    check("wrap_second", {30'd0, bus.oGntIdx}, 32'd0);
    step(4'b0001, 1'b1);

    // All four held from reset, ack 2 cycles after each grant: order m0,m1,m2,m3,m0
    do_reset();
    for (int t = 0; t < 5; t++) begin
      step(4'b1111, 1'b0);
      order_q.push_back(int'(bus.oGntIdx));
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b1);
      check("bubble", {31'd0, bus.oGntVld}, 32'd0);
    end
    for (int t = 0; t < 5; t++) check("rr_order", order_q[t], t % 4);

    // Abort: m1 granted, drops its request without ack
    do_reset();
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    check("abort_ptr", {30'd0, bus.oDbgPtr}, 32'd2);

    // Spurious ack in IDLE
    step(4'b0000, 1'b1);
    check("spur_state", {31'd0, bus.oDbgState}, 32'd0);

    // Long hold without ack (times out when the timeout is built)
    for (int t = 0; t < 300; t++) step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Async reset mid-grant
    step(4'b0100, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt", {28'd0, bus.oGnt},    32'd0);
    check("arst_vld", {31'd0, bus.oGntVld}, 32'd0);
    check("arst_ptr", {30'd0, bus.oDbgPtr}, 32'd0);
    do_reset();

    // Random traffic: requests toggle sparsely, acks random (including spurious)
    r_req = 4'b0000;
    hold  = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) r_req[b] = ~r_req[b];
      end
      if (hold > 0) hold--;
      step(r_req, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
